// File: rtl/cpu_pkg.sv
// Shared fetch-path constants and the entry type carried by the prefetch queue.
package cpu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h1c00_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO with flush; wrap-bit pointers give count 0..DEPTH.
module ifq_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = fetch_entry_t,
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  T            push_data,
    input  logic        pop,
    input  logic        flush,
    output logic        full,
    output logic        empty,
    output logic [PW:0] count,
    output T            head
);

    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;
    T            r_mem [DEPTH];

    assign count = r_wptr - r_rptr;
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (r_wptr == r_rptr);
    assign head  = r_mem[r_rptr[PW-1:0]];

    // Push while full is legal only together with a pop: the slot written is the head being read out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push) begin
                r_mem[r_wptr[PW-1:0]] <= push_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: credit-limited sequential fetch, in-order delivery, one-cycle redirect flush.
// Optional IFQ_BYPASS_EN: a response arriving at an empty queue is presented to ID in the same cycle.
module if_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned       INST_W   = cpu_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_sram_en,
    output logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [INST_W-1:0] inst_sram_rdata,
    output logic              out_valid,
    input  logic              out_allowin,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inflight_valid;
    logic [ADDR_W-1:0] r_inflight_pc;

    logic              w_full;
    logic              w_empty;
    logic [PW:0]       w_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_resp;
    logic              w_resp_bypass;
    logic              w_redirect;
    logic              w_pop;
    logic              w_fifo_pop;
    logic              w_push;
    logic [PW+1:0]     w_outstanding;
    logic              w_issue;

    assign w_redirect    = resetn & redirect_valid;
    assign w_resp.pc     = r_inflight_pc;
    assign w_resp.inst   = inst_sram_rdata;
    assign w_outstanding = {1'b0, w_count} + (PW+2)'(r_inflight_valid);

`ifdef IFQ_BYPASS_EN
    assign w_resp_bypass = r_inflight_valid & w_empty;
`else
    assign w_resp_bypass = 1'b0;
`endif

    always_comb begin
        out_valid = ~w_redirect & (~w_empty | w_resp_bypass);
        out_pc    = w_head.pc;
        out_inst  = w_head.inst;
        if (w_resp_bypass) begin
            out_pc   = w_resp.pc;
            out_inst = w_resp.inst;
        end
        w_pop      = out_valid & out_allowin;
        w_fifo_pop = w_pop & ~w_empty;
        // A bypassed response that ID takes immediately never occupies a slot.
        w_push     = r_inflight_valid & ~w_redirect & ~(w_resp_bypass & w_pop)
                   & (~w_full | w_fifo_pop);
        w_issue    = resetn & (w_redirect | (w_outstanding < (PW+2)'(DEPTH)) | w_pop);
        inst_sram_en   = w_issue;
        inst_sram_addr = w_redirect ? redirect_pc : r_fetch_pc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fetch_pc       <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= '0;
        end else if (w_issue) begin
            r_fetch_pc       <= inst_sram_addr + ADDR_W'(4);
            r_inflight_valid <= 1'b1;
            r_inflight_pc    <= inst_sram_addr;
        end else begin
            r_inflight_valid <= 1'b0;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_push),
        .push_data (w_resp),
        .pop       (w_fifo_pop),
        .flush     (w_redirect),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .head      (w_head)
    );

endmodule
